// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed seven-segment scan with dead time, LZS, blanking and double-buffered frame updates
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    ssd_scan_ctrl_port_clk,
    input  logic                    ssd_scan_ctrl_port_rst_n,
    input  logic [4*NUM_DIGITS-1:0] ssd_scan_ctrl_port_data,
    input  logic                    ssd_scan_ctrl_port_load,
    input  logic [NUM_DIGITS-1:0]   ssd_scan_ctrl_port_blank_mask,
    input  logic                    ssd_scan_ctrl_port_lzs_en,
    output logic [3:0]              ssd_scan_ctrl_port_digit,
    output logic [NUM_DIGITS-1:0]   ssd_scan_ctrl_port_an_n,
    output logic                    ssd_scan_ctrl_port_seg_blank,
    output logic                    ssd_scan_ctrl_port_frame_done
);
    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {S_BLANK, S_SHOW} state_t;

    // The scan position (state, counter, index) runs one cycle ahead of the
    // registered outputs, so every output flop is loaded from the position
    // it is about to present.
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         stage_q, stage_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic                  pend_q, pend_d;
    logic [3:0]            digit_q, digit_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  seg_blank_q, seg_blank_d;
    logic                  frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0] lz, dark;
    logic                  all_zero, slot_end, frame_start;

    // Darkness per digit: explicit mask, or leading zero (digit 0 always kept)
    always_comb begin
        all_zero = 1'b1;
        lz = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (shadow_q[4*i +: 4] == 4'd0);
            lz[i] = all_zero & (i != 0);
        end
        dark = ssd_scan_ctrl_port_blank_mask | ({NUM_DIGITS{ssd_scan_ctrl_port_lzs_en}} & lz);
    end

    // Next-state for scan FSM, load buffering and the registered outputs
    always_comb begin
        slot_end    = cnt_q == CNT_LAST;
        frame_start = (cnt_q == '0) && (idx_q == '0);
        state_d     = slot_end ? S_BLANK
                    : (state_q == S_BLANK && cnt_q == BLANK_LAST) ? S_SHOW : state_q;
        cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
        idx_d       = !slot_end ? idx_q : (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        stage_d     = ssd_scan_ctrl_port_load ? ssd_scan_ctrl_port_data : stage_q;
        pend_d      = frame_start ? 1'b0 : (pend_q | ssd_scan_ctrl_port_load);
        shadow_d    = !frame_start ? shadow_q
                    : ssd_scan_ctrl_port_load ? ssd_scan_ctrl_port_data
                    : pend_q ? stage_q : shadow_q;
        digit_d     = (state_q == S_BLANK && cnt_q == '0) ? shadow_d[4*idx_q +: 4] : digit_q;
        an_n_d      = '1;
        if (state_q == S_SHOW && !dark[idx_q])
            an_n_d[idx_q] = 1'b0;
        seg_blank_d  = &an_n_d;
        frame_done_d = frame_start;
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge ssd_scan_ctrl_port_clk or negedge ssd_scan_ctrl_port_rst_n) begin
        if (!ssd_scan_ctrl_port_rst_n) begin
            state_q      <= S_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            stage_q      <= '0;
            shadow_q     <= '0;
            pend_q       <= 1'b0;
            digit_q      <= 4'd0;
            an_n_q       <= '1;
            seg_blank_q  <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stage_q      <= stage_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            digit_q      <= digit_d;
            an_n_q       <= an_n_d;
            seg_blank_q  <= seg_blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ssd_scan_ctrl_port_digit      = digit_q;
    assign ssd_scan_ctrl_port_an_n       = an_n_q;
    assign ssd_scan_ctrl_port_seg_blank  = seg_blank_q;
    assign ssd_scan_ctrl_port_frame_done = frame_done_q;
endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one `ssd_driver` decoder. It holds a double-buffered display word and steps through the digits at a fixed refresh rate. For each digit slot it presents that digit's nibble to the decoder and drives the matching active-low anode enable. Each slot begins with an anti-ghosting dead time, and the block also provides leading-zero suppression, per-digit blanking and atomic frame-boundary updates.

## Interface

Parameters:
- `NUM_DIGITS`, 4: number of digits scanned; legal range 1..8.
- `DIGIT_CYCLES`, 100000: clock cycles per digit slot; must be at least 2.
- `BLANK_CYCLES`, 1000: dead-time cycles at the start of each slot; legal range 1..`DIGIT_CYCLES`-1.

Ports:
- `ssd_scan_ctrl_port_clk`, in, 1: single system clock; all state changes on the rising edge.
- `ssd_scan_ctrl_port_rst_n`, in, 1: reset, asynchronous, active-low.
- `ssd_scan_ctrl_port_data`, in, 4*`NUM_DIGITS`: display word; nibble i is digit i, and digit 0 is least significant.
- `ssd_scan_ctrl_port_load`, in, 1: one-cycle strobe that captures `data` into the staging register.
- `ssd_scan_ctrl_port_blank_mask`, in, `NUM_DIGITS`: bit i = 1 forces digit i dark; sampled live.
- `ssd_scan_ctrl_port_lzs_en`, in, 1: enables leading-zero suppression; sampled live.
- `ssd_scan_ctrl_port_digit`, out, 4: nibble for the current slot, fed to the `ssd_driver` input.
- `ssd_scan_ctrl_port_an_n`, out, `NUM_DIGITS`: anode enables, active-low, with at most one bit low at a time.
- `ssd_scan_ctrl_port_seg_blank`, out, 1: 1 whenever no anode is active; used to gate the segment lines.
- `ssd_scan_ctrl_port_frame_done`, out, 1: one-cycle pulse at each frame boundary.

## Operation

- Registers: staging word, shadow word (the displayed word), pending flag, slot cycle counter, digit index, and a 2-state FSM.
- FSM states:
  - `S_BLANK`: all anodes high and `seg_blank`=1. Moves to `S_SHOW` when the counter reaches `BLANK_CYCLES`-1.
  - `S_SHOW`: `an_n[idx]`=0 unless the digit is dark. Moves to `S_BLANK` of slot idx+1 when the counter reaches `DIGIT_CYCLES`-1.
- The counter is $clog2(`DIGIT_CYCLES`) bits wide. It resets to 0 at each slot start and runs continuously across both states.
- The digit index increments at the end of each slot and wraps from `NUM_DIGITS`-1 to 0.
- `digit` is updated on the first cycle of each slot (the first `S_BLANK` cycle) to shadow nibble idx. It stays constant for the whole slot.
- Load handling:
  - When `load`=1, staging takes `data` and pending is set.
  - At the frame boundary (last cycle of slot `NUM_DIGITS`-1): if pending is set, or `load`=1 in that same cycle, shadow takes the new value (`data` when `load`=1, otherwise staging). Pending is then cleared.
  - Loads during a frame never alter the frame in progress. The last load before the boundary wins.
- A digit i is dark when either condition holds:
  - `blank_mask[i]`=1.
  - `lzs_en`=1, i > 0, and nibble i together with every more-significant nibble of the shadow word are all 0.
- Digit 0 is never suppressed by LZS, so zero displays as "0".
- A dark digit keeps its anode high for the whole slot and holds `seg_blank`=1. Slot timing is unchanged, so frame length stays constant.
- `frame_done`=1 for exactly the first cycle of slot 0 (the cycle after the boundary), when the new shadow word is in effect.

## Timing

- Reset values while `rst_n`=0, applied immediately without waiting for a clock edge:
  - `an_n` all 1s, `seg_blank`=1, `digit`=0, `frame_done`=0.
  - FSM in `S_BLANK`, index 0, counter 0.
  - Staging=0, shadow=0, pending=0.
- Reset mid-slot: anodes go high immediately. Scanning restarts at slot 0 `S_BLANK` after release.
- Relative to the first rising edge after release (cycle 0, slot 0):
  - Cycle 0: `frame_done`=1.
  - Cycles `BLANK_CYCLES`..`DIGIT_CYCLES`-1: `an_n[0]`=0.
  - Frame period: `NUM_DIGITS`*`DIGIT_CYCLES` cycles.
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency from `load` to display: at most one full frame plus one cycle.
- `blank_mask` and `lzs_en` are sampled on every `S_SHOW` cycle, so they take effect one cycle after they change.

## Test plan

All scenarios use `NUM_DIGITS`=4, `DIGIT_CYCLES`=8, `BLANK_CYCLES`=2.

- Reset, then release:
  - Stimulus: hold `rst_n`=0, then release.
  - Required: all reset values hold during reset.
  - Required: `an_n[0]`=0 on cycles 2–7, `an_n[1]`=0 on cycles 10–15, `frame_done` pulses at cycles 0, 32, 64.
- Load `16'h12A4` during frame 0:
  - Required: frame 0 shows 0,0,0,0.
  - Required: frame 1 shows `digit` sequence 4, A, 2, 1, one value per 8-cycle slot.
- LZS with `lzs_en`=1:
  - `16'h0005`: only `an_n[0]` ever asserts.
  - `16'h0105`: digits 0, 1, 2 light and digit 1 shows 0.
  - `16'h0000`: only digit 0 lights, showing 0.
- Double load:
  - Stimulus: load `16'h1111` in slot 1, then `16'h2222` in slot 2.
  - Required: the current frame is unchanged and the next frame shows 2,2,2,2.
  - Stimulus: load on the boundary cycle (cycle 31).
  - Required: the loaded value is displayed from cycle 32.
- Blank mask:
  - Stimulus: `blank_mask`=4'b0010.
  - Required: `an_n[1]` stays high throughout, `seg_blank`=1 for cycles 8–15, and the frame period is still 32.
- Asynchronous reset mid-operation:
  - Stimulus: drop `rst_n` while `an_n[2]`=0.
  - Required: `an_n` goes to all 1s before the next clock edge.
  - Required: after release, the scan restarts at slot 0 and the shadow word is 0.
